// File: rtl/flight_pkg.sv
// Shared types, sizes and arithmetic helpers for the flight controller slice.
package flight_pkg;

    localparam int PLANET_N = 8;
    localparam int IDX_W    = 3;

    typedef enum logic [1:0] {
        PH_BOUND    = 2'b00,
        PH_LEAVING  = 2'b01,
        PH_UNBOUND  = 2'b10,
        PH_ARRIVING = 2'b11
    } phase_t;

    typedef enum logic [2:0] {
        FS_BOUND    = 3'd0,
        FS_LEAVING  = 3'd1,
        FS_UNBOUND  = 3'd2,
        FS_ARRIVING = 3'd3,
        FS_DEAD     = 3'd4,
        FS_OVER     = 3'd5
    } fsm_t;

    // Magnitude of a 17-bit two's-complement value; -65536 maps to 65536.
    function automatic logic [16:0] abs17(input logic [16:0] v);
        abs17 = v[16] ? (17'd0 - v) : v;
    endfunction

    function automatic logic [33:0] sq17(input logic [16:0] m);
        sq17 = {17'd0, m} * {17'd0, m};
    endfunction

    // DEAD reports as arriving so the datapath parks the vessel; OVER reports bound.
    function automatic phase_t phase_of(input fsm_t f);
        case (f)
            FS_BOUND:    phase_of = PH_BOUND;
            FS_LEAVING:  phase_of = PH_LEAVING;
            FS_UNBOUND:  phase_of = PH_UNBOUND;
            FS_ARRIVING: phase_of = PH_ARRIVING;
            FS_DEAD:     phase_of = PH_ARRIVING;
            FS_OVER:     phase_of = PH_BOUND;
            default:     phase_of = PH_BOUND;
        endcase
    endfunction

endpackage

// File: rtl/capture_detect.sv
// Combinational orbital-capture test of the vessel against every planet except
// the one it departed; reports the lowest qualifying planet index.
module capture_detect
    import flight_pkg::*;
#(
    parameter int CAPTURE_K = 2
)(
    input  logic [15:0]                vessel_x,
    input  logic [15:0]                vessel_y,
    input  logic [PLANET_N-1:0][15:0]  planet_x,
    input  logic [PLANET_N-1:0][15:0]  planet_y,
    input  logic [PLANET_N-1:0][15:0]  planet_s,
    input  logic [IDX_W-1:0]           origin,
    output logic                       hit,
    output logic [IDX_W-1:0]           hit_idx
);

    logic [PLANET_N-1:0] cand_s;

    for (genvar g = 0; g < PLANET_N; g++) begin : g_planet
        logic [16:0] dx_s;
        logic [16:0] dy_s;
        logic [16:0] rad_s;
        logic [33:0] dist_sq_s;
        logic [33:0] rad_sq_s;

        // Squares of magnitudes equal squares of the signed differences.
        assign dx_s      = abs17({planet_x[g][15], planet_x[g]} - {vessel_x[15], vessel_x});
        assign dy_s      = abs17({planet_y[g][15], planet_y[g]} - {vessel_y[15], vessel_y});
        assign rad_s     = 17'(abs17({planet_s[g][15], planet_s[g]}) * 17'(CAPTURE_K));
        assign dist_sq_s = sq17(dx_s) + sq17(dy_s);
        assign rad_sq_s  = sq17(rad_s);
        assign cand_s[g] = (dist_sq_s <= rad_sq_s) && (IDX_W'(g) != origin);
    end

    // Descending scan so the lowest qualifying index is the one left standing.
    always_comb begin
        hit_idx = {IDX_W{1'b0}};
        for (int i = PLANET_N - 1; i >= 0; i--) begin
            hit_idx = cand_s[i] ? IDX_W'(i) : hit_idx;
        end
    end

    assign hit = |cand_s;

endmodule

// File: rtl/flight_sequencer.sv
// Frame-rate flight controller: launch edge detect, phase sequencing, capture,
// crash/respawn, lives, win and game-over bookkeeping.
module flight_sequencer
    import flight_pkg::*;
#(
    parameter logic [7:0] LAUNCH_KEY     = 8'h2C,
    parameter logic [7:0] LEAVE_FRAMES   = 8'd8,
    parameter logic [7:0] ARRIVE_FRAMES  = 8'd2,
    parameter logic [7:0] RESPAWN_FRAMES = 8'd60,
    parameter int         CAPTURE_K      = 2,
    parameter logic [2:0] HOME_PLANET    = 3'd0,
    parameter logic [2:0] WIN_PLANET     = 3'd4,
    parameter logic [2:0] START_LIVES    = 3'd3
)(
    input  logic                       frame_clk,
    input  logic                       Reset,
    input  logic [15:0]                keycode,
    input  logic                       crash,
    input  logic [15:0]                vessel_x,
    input  logic [15:0]                vessel_y,
    input  logic [PLANET_N-1:0][15:0]  planet_x,
    input  logic [PLANET_N-1:0][15:0]  planet_y,
    input  logic [PLANET_N-1:0][15:0]  planet_s,
    output logic [1:0]                 state,
    output logic [2:0]                 curplan,
    output logic [2:0]                 origin,
    output logic [2:0]                 lives,
    output logic                       win,
    output logic                       game_over
);

    fsm_t        fsm_r, fsm_nxt_s;
    phase_t      state_r;
    logic [7:0]  cnt_r, cnt_nxt_s;
    logic        launch_prev_r;
    logic [2:0]  curplan_r, curplan_nxt_s;
    logic [2:0]  origin_r, origin_nxt_s;
    logic [2:0]  lives_r, lives_nxt_s;
    logic        win_r, win_nxt_s;
    logic        game_over_r, game_over_nxt_s;
    logic        key_hit_s, launch_s;
    logic        cap_hit_s;
    logic [2:0]  cap_idx_s;

    assign key_hit_s = (keycode[7:0] == LAUNCH_KEY) || (keycode[15:8] == LAUNCH_KEY);
    assign launch_s  = key_hit_s && !launch_prev_r;

    capture_detect #(.CAPTURE_K(CAPTURE_K)) u_capture (
        .vessel_x (vessel_x),
        .vessel_y (vessel_y),
        .planet_x (planet_x),
        .planet_y (planet_y),
        .planet_s (planet_s),
        .origin   (origin_r),
        .hit      (cap_hit_s),
        .hit_idx  (cap_idx_s)
    );

    // Next-state, counter and bookkeeping decisions for the flight FSM.
    always_comb begin
        fsm_nxt_s       = fsm_r;
        cnt_nxt_s       = cnt_r;
        curplan_nxt_s   = curplan_r;
        origin_nxt_s    = origin_r;
        lives_nxt_s     = lives_r;
        win_nxt_s       = win_r;
        game_over_nxt_s = game_over_r;
        case (fsm_r)
            FS_BOUND: begin
                if (launch_s) begin
                    origin_nxt_s = curplan_r;
                    cnt_nxt_s    = 8'd0;
                    fsm_nxt_s    = FS_LEAVING;
                end else begin
                    fsm_nxt_s    = FS_BOUND;
                end
            end
            FS_LEAVING: begin
                if (cnt_r == LEAVE_FRAMES - 8'd1) begin
                    cnt_nxt_s = 8'd0;
                    fsm_nxt_s = FS_UNBOUND;
                end else begin
                    cnt_nxt_s = cnt_r + 8'd1;
                end
            end
            FS_UNBOUND: begin
                if (crash) begin
                    // Lives freeze once the game is won.
                    lives_nxt_s   = (win_r || (lives_r == 3'd0)) ? lives_r : lives_r - 3'd1;
                    curplan_nxt_s = HOME_PLANET;
                    cnt_nxt_s     = 8'd0;
                    fsm_nxt_s     = FS_DEAD;
                end else if (cap_hit_s) begin
                    curplan_nxt_s = cap_idx_s;
                    cnt_nxt_s     = 8'd0;
                    fsm_nxt_s     = FS_ARRIVING;
                end else begin
                    fsm_nxt_s     = FS_UNBOUND;
                end
            end
            FS_ARRIVING: begin
                if (cnt_r == ARRIVE_FRAMES - 8'd1) begin
                    cnt_nxt_s = 8'd0;
                    fsm_nxt_s = FS_BOUND;
                    win_nxt_s = win_r || (curplan_r == WIN_PLANET);
                end else begin
                    cnt_nxt_s = cnt_r + 8'd1;
                end
            end
            FS_DEAD: begin
                if (lives_r == 3'd0) begin
                    game_over_nxt_s = 1'b1;
                    cnt_nxt_s       = 8'd0;
                    fsm_nxt_s       = FS_OVER;
                end else if (cnt_r == RESPAWN_FRAMES - 8'd1) begin
                    curplan_nxt_s   = HOME_PLANET;
                    origin_nxt_s    = HOME_PLANET;
                    cnt_nxt_s       = 8'd0;
                    fsm_nxt_s       = FS_BOUND;
                end else begin
                    cnt_nxt_s       = cnt_r + 8'd1;
                end
            end
            FS_OVER: begin
                fsm_nxt_s = FS_OVER;
            end
            default: begin
                cnt_nxt_s = 8'd0;
                fsm_nxt_s = FS_BOUND;
            end
        endcase
    end

    // State and output registers; the phase code is registered from the next state.
    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            fsm_r         <= FS_BOUND;
            state_r       <= PH_BOUND;
            cnt_r         <= 8'd0;
            launch_prev_r <= 1'b0;
            curplan_r     <= HOME_PLANET;
            origin_r      <= HOME_PLANET;
            lives_r       <= START_LIVES;
            win_r         <= 1'b0;
            game_over_r   <= 1'b0;
        end else begin
            fsm_r         <= fsm_nxt_s;
            state_r       <= phase_of(fsm_nxt_s);
            cnt_r         <= cnt_nxt_s;
            launch_prev_r <= key_hit_s;
            curplan_r     <= curplan_nxt_s;
            origin_r      <= origin_nxt_s;
            lives_r       <= lives_nxt_s;
            win_r         <= win_nxt_s;
            game_over_r   <= game_over_nxt_s;
        end
    end

    assign state     = state_r;
    assign curplan   = curplan_r;
    assign origin    = origin_r;
    assign lives     = lives_r;
    assign win       = win_r;
    assign game_over = game_over_r;

endmodule

// File: tb/tb_flight_sequencer.sv
// Scoreboard bench for flight_sequencer: stimulus pushes per-frame expected
// outputs, a monitor pops and compares one entry after every frame edge.
module tb_flight_sequencer;

    localparam logic [15:0] FAR = 16'hB1E0;  // -20000

    logic                frame_clk = 1'b0;
    logic                Reset;
    logic [15:0]         keycode;
    logic                crash;
    logic [15:0]         vessel_x, vessel_y;
    logic [7:0][15:0]    planet_x, planet_y, planet_s;
    logic [1:0]          state;
    logic [2:0]          curplan, origin, lives;
    logic                win, game_over;

    typedef struct {
        logic [1:0] st;
        logic [2:0] cp;
        logic [2:0] org;
        logic [2:0] lv;
        logic       w;
        logic       go;
        string      tag;
    } exp_t;

    exp_t        sb_q[$];
    int          tests = 0;
    int          fails = 0;
    logic [1:0]  e_st;
    logic [2:0]  e_cp, e_org, e_lv;
    logic        e_w, e_go;
    string       e_tag;

    always #5 frame_clk = ~frame_clk;

    flight_sequencer dut (
        .frame_clk (frame_clk),
        .Reset     (Reset),
        .keycode   (keycode),
        .crash     (crash),
        .vessel_x  (vessel_x),
        .vessel_y  (vessel_y),
        .planet_x  (planet_x),
        .planet_y  (planet_y),
        .planet_s  (planet_s),
        .state     (state),
        .curplan   (curplan),
        .origin    (origin),
        .lives     (lives),
        .win       (win),
        .game_over (game_over)
    );

    // Monitor: one expected frame per active edge, compared #1 after it.
    initial begin
        exp_t e;
        forever begin
            @(posedge frame_clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                tests++;
                if ({state, curplan, origin, lives, win, game_over} !==
                    {e.st, e.cp, e.org, e.lv, e.w, e.go}) begin
                    fails++;
                    $display("FAIL %s: got st=%b cp=%0d org=%0d lv=%0d win=%b go=%b, expected st=%b cp=%0d org=%0d lv=%0d win=%b go=%b",
                             e.tag, state, curplan, origin, lives, win, game_over,
                             e.st, e.cp, e.org, e.lv, e.w, e.go);
                end
            end
        end
    end

    task automatic step();
        exp_t e;
        e.st = e_st; e.cp = e_cp; e.org = e_org; e.lv = e_lv;
        e.w = e_w; e.go = e_go; e.tag = e_tag;
        sb_q.push_back(e);
        @(negedge frame_clk);
    endtask

    task automatic exp_reset(input string tag);
        e_st = 2'b00; e_cp = 3'd0; e_org = 3'd0; e_lv = 3'd3;
        e_w = 1'b0; e_go = 1'b0; e_tag = tag;
    endtask

    task automatic pulse_reset(input string tag);
        Reset = 1'b1;
        exp_reset(tag);
        step();
        step();
        Reset = 1'b0;
        step();
    endtask

    // Launch from the current planet: 8 leaving frames, then one unbound frame.
    task automatic fly_out(input logic [15:0] key, input string tag);
        keycode = key;
        e_org   = e_cp;
        e_st    = 2'b01;
        e_tag   = tag;
        step();
        keycode = 16'h0000;
        repeat (7) step();
        e_st = 2'b10;
        step();
    endtask

    // Crash from unbound: 60 parked frames at home, then bound at home.
    task automatic crash_respawn(input logic dec, input string tag);
        crash = 1'b1;
        e_st  = 2'b11;
        e_cp  = 3'd0;
        e_lv  = dec ? e_lv - 3'd1 : e_lv;
        e_tag = tag;
        step();
        crash    = 1'b0;
        vessel_x = FAR;
        vessel_y = FAR;
        repeat (59) step();
        e_st  = 2'b00;
        e_org = 3'd0;
        step();
    endtask

    initial begin
        Reset    = 1'b1;
        keycode  = 16'h0000;
        crash    = 1'b0;
        vessel_x = FAR;
        vessel_y = FAR;
        for (int i = 0; i < 8; i++) begin
            planet_x[i] = 16'(2000 + 1000 * i);
            planet_y[i] = 16'd0;
            planet_s[i] = 16'd8;
        end
        planet_x[2] = 16'd310;
        planet_y[2] = 16'd200;

        pulse_reset("reset");

        // Held key: exactly one launch, 8 leaving frames, then unbound.
        keycode = 16'h002C;
        e_st = 2'b01; e_tag = "leave_held_key";
        repeat (8) step();
        e_st = 2'b10; e_tag = "unbound_held_key";
        repeat (12) step();
        keycode = 16'h0000;
        step();

        // Inside origin planet 0 only: no capture.
        vessel_x = 16'd2005; vessel_y = 16'd0;
        e_tag = "origin_excluded";
        repeat (3) step();

        // Capture planet 2 at d^2 = 100.
        vessel_x = 16'd300; vessel_y = 16'd200;
        e_st = 2'b11; e_cp = 3'd2; e_tag = "capture_p2_arriving";
        step();
        step();
        e_st = 2'b00; e_tag = "capture_p2_bound";
        step();
        vessel_x = FAR; vessel_y = FAR;

        fly_out(16'h2C00, "launch_high_byte");

        // Crash and planet 3 capture in the same frame: crash wins.
        vessel_x = 16'd5000; vessel_y = 16'd0;
        crash_respawn(1'b1, "crash_over_capture");

        // Reset honoured while dead.
        fly_out(16'h002C, "launch_before_reset");
        crash = 1'b1;
        e_st = 2'b11; e_cp = 3'd0; e_lv = 3'd1; e_tag = "dead_before_reset";
        step();
        crash = 1'b0;
        repeat (3) step();
        pulse_reset("reset_mid_dead");

        // Three crashes to game over.
        fly_out(16'h002C, "launch_c1");
        crash_respawn(1'b1, "crash_1");
        fly_out(16'h002C, "launch_c2");
        crash_respawn(1'b1, "crash_2");
        fly_out(16'h002C, "launch_c3");
        crash = 1'b1;
        e_st = 2'b11; e_cp = 3'd0; e_lv = 3'd0; e_tag = "crash_3_dead";
        step();
        crash = 1'b0;
        e_st = 2'b00; e_go = 1'b1; e_tag = "game_over";
        step();
        keycode = 16'h002C;
        e_tag = "over_ignores_launch";
        repeat (5) step();
        keycode = 16'h0000;
        step();
        pulse_reset("reset_after_over");

        // Win at planet 4, with the capture radius boundary probed first.
        fly_out(16'h002C, "launch_win");
        vessel_x = 16'd6000; vessel_y = 16'd17;
        e_tag = "just_outside_radius";
        step();
        vessel_y = 16'd16;
        e_st = 2'b11; e_cp = 3'd4; e_tag = "capture_on_radius";
        step();
        step();
        e_st = 2'b00; e_w = 1'b1; e_tag = "win_set";
        step();
        vessel_x = FAR; vessel_y = FAR;
        fly_out(16'h002C, "launch_after_win");
        vessel_x = 16'd5000; vessel_y = 16'd0;
        crash_respawn(1'b0, "crash_after_win");

        tests++;
        if (sb_q.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
